segment_rx: RTL
===============

# segment_rx

Reverse of the dual-digit seven-segment encoder. Watches the two 9-bit segment buses driven to the board's display pair and recovers the displayed digits. Each bus is synchronised and debounced. Each new stable digit pair is delivered on a valid/ready output port. Used for display loopback self-test and as a bench monitor for display-driving logic.

## Interface
Parameters:
- STABLE_CYCLES, default 8, consecutive identical synchronised samples required before a bus counts as stable; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- segment_led_1  in  9  display 1 bus; bit 8 = DIG, bit 7 = DP, bits 6:0 = G,F,E,D,C,B,A
- segment_led_2  in  9  display 2 bus; same bit order
- out_ready  in  1  consumer accepts the current pair
- out_valid  out  1  a pair is held on the output
- digit_1, digit_2  out  4  decoded digits
- err_1, err_2  out  1  pattern on bits 6:0 is not a legal digit
- blank_1, blank_2  out  1  DIG = 1, so the digit is disabled
- overrun  out  1  sticky flag: a held pair was superseded before it was accepted

## Operation
- Synchroniser: 2-flop synchroniser on every input bit (s1, then s2).
- Stability tracker, one per channel:
  - Registers cand[8:0] and cnt, with cnt width clog2(STABLE_CYCLES+1).
  - On each edge, if s2 ≠ cand: cand ← s2, cnt ← 1.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
  - The channel is stable when cnt == STABLE_CYCLES.
- Decode is combinational from cand. DP (bit 7) is ignored.
- If DIG = 1: digit = 4'hF, blank = 1, err = 0.
- Otherwise bits 6:0 map to digits: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
- Any other value on bits 6:0: digit = 4'hE, err = 1.
- Event: both channels stable, and the {cand_1, cand_2} pair differs from last_pair, or no pair has been reported since reset.
- Output register behaviour on an event:
  - If out_valid = 0, or out_valid = 1 and out_ready = 1 on the same edge: load the decoded fields, set out_valid = 1, last_pair ← pair.
  - If out_valid = 1 and out_ready = 0: the held data is kept and overrun is set (sticky). last_pair is not updated, so the newer pair is emitted after the held pair is accepted, provided it is still stable.
- Transfer occurs on any edge where out_valid = 1 and out_ready = 1. out_valid falls on that edge unless a new event loads on the same edge.
- While out_valid = 1 and out_ready = 0, all output fields are held constant.
- Glitch rejection: a change shorter than STABLE_CYCLES samples that returns to the previous value produces no event, because the pair still equals last_pair.
- Reset values:
  - out_valid, digit_*, err_*, blank_*, overrun are all 0.
  - s1, s2, cand are 0; cnt is 0; the "reported" flag is cleared.
- Reset mid-operation discards any held pair. The first stable pair after reset is reported even if it equals the pre-reset pair.

## Timing
- Input value first sampled at edge N:
  - s2 holds it after edge N+1.
  - cnt reaches STABLE_CYCLES after edge N+1+STABLE_CYCLES.
  - out_valid rises after edge N+2+STABLE_CYCLES.
  - Total latency is STABLE_CYCLES+3 edges: 11 at the default.
- If the two channels settle at different times, latency is measured from the later channel.
- out_ready is sampled only at clock edges. There is no combinational path from out_ready to any output.
- Throughput is at most one pair per STABLE_CYCLES+1 clocks per distinct input change.

## Test plan
- Reset, then hold both buses at 0x03F and out_ready = 1 → out_valid pulses once, 11 edges after the first sample, with digit_1 = 0, digit_2 = 0, no err, no blank. No further events while the input is held.
- Cycle both buses through codes 0–9 (display 2 lagging display 1 by one digit), each held 20 clocks → ten pairs delivered in order, e.g. {3,2} for 0x04F/0x05B; no err.
- Drive display 1 with 0x07F for 3 clocks inside a steady 0x006 (STABLE_CYCLES = 8) → no event; outputs stay at the {1,x} pair.
- Drive display 1 with 0x100, display 2 with 0x049 → digit_1 = F with blank_1 = 1; digit_2 = E with err_2 = 1.
- Hold out_ready = 0 and deliver {1,1}, then change to {2,2} and let it stabilise → {1,1} is held unchanged and overrun = 1. Raising out_ready delivers {1,1}, then {2,2} on the next edge.
- Assert rst for 1 cycle while out_valid = 1 → all outputs 0 on the next edge. The unchanged input pair is re-reported 11 edges after rst is released.

Source files
------------

// File: rtl/segment_rx.sv
// Recovers the digit pair shown on two 9-bit seven-segment buses: each bus is
// synchronised and debounced, and every new stable pair is offered on a valid/ready port.
module segment_rx #(
    parameter int STABLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] segment_led_1,
    input  logic [8:0] segment_led_2,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic       err_1,
    output logic       err_2,
    output logic       blank_1,
    output logic       blank_2,
    output logic       overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [8:0]    s1_1, s2_1, cand_1;
    logic [8:0]    s1_2, s2_2, cand_2;
    logic [CW-1:0] cnt_1, cnt_2;
    logic [17:0]   last_pair;
    logic          reported;

    logic          stable_1, stable_2;
    logic [17:0]   pair;
    logic          pair_event, load;
    logic [5:0]    dec_1, dec_2;

    // Packed result is {digit[3:0], err, blank}; DP never reaches the decoder.
    function automatic logic [5:0] decode(input logic dig, input logic [6:0] seg);
        logic [5:0] res;
        if (dig) begin
            res = {4'hF, 1'b0, 1'b1};
        end else begin
            case (seg)
                7'h3F:   res = {4'd0, 2'b00};
                7'h06:   res = {4'd1, 2'b00};
                7'h5B:   res = {4'd2, 2'b00};
                7'h4F:   res = {4'd3, 2'b00};
                7'h66:   res = {4'd4, 2'b00};
                7'h6D:   res = {4'd5, 2'b00};
                7'h7D:   res = {4'd6, 2'b00};
                7'h07:   res = {4'd7, 2'b00};
                7'h7F:   res = {4'd8, 2'b00};
                7'h6F:   res = {4'd9, 2'b00};
                default: res = {4'hE, 1'b1, 1'b0};
            endcase
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_1 <= '0;
            s2_1 <= '0;
            s1_2 <= '0;
            s2_2 <= '0;
        end else begin
            s1_1 <= segment_led_1;
            s2_1 <= s1_1;
            s1_2 <= segment_led_2;
            s2_2 <= s1_2;
        end
    end

    // Any change restarts the run at one sample; an unchanged bus counts up and saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_1 <= '0;
            cnt_1  <= '0;
            cand_2 <= '0;
            cnt_2  <= '0;
        end else begin
            if (s2_1 != cand_1) begin
                cand_1 <= s2_1;
                cnt_1  <= CW'(1);
            end else if (cnt_1 != CNT_MAX) begin
                cnt_1 <= cnt_1 + CW'(1);
            end
            if (s2_2 != cand_2) begin
                cand_2 <= s2_2;
                cnt_2  <= CW'(1);
            end else if (cnt_2 != CNT_MAX) begin
                cnt_2 <= cnt_2 + CW'(1);
            end
        end
    end

    always_comb begin
        dec_1      = decode(cand_1[8], cand_1[6:0]);
        dec_2      = decode(cand_2[8], cand_2[6:0]);
        stable_1   = (cnt_1 == CNT_MAX);
        stable_2   = (cnt_2 == CNT_MAX);
        pair       = {cand_1, cand_2};
        pair_event = stable_1 && stable_2 && (!reported || (pair != last_pair));
        load       = pair_event && (!out_valid || out_ready);
    end

    // A blocked event leaves last_pair alone so the newer pair is retried after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            digit_1   <= '0;
            digit_2   <= '0;
            err_1     <= 1'b0;
            err_2     <= 1'b0;
            blank_1   <= 1'b0;
            blank_2   <= 1'b0;
            overrun   <= 1'b0;
            last_pair <= '0;
            reported  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            {digit_1, err_1, blank_1} <= dec_1;
            {digit_2, err_2, blank_2} <= dec_2;
            last_pair <= pair;
            reported  <= 1'b1;
        end else begin
            if (pair_event) begin
                overrun <= 1'b1;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
